uart_receiver: RTL and testbench



---
 rtl/uart_receiver_if.sv | 32 +++
 rtl/uart_receiver.sv | 140 ++++++++++++++
 tb/tb_uart_receiver.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Receive-side bundle of the UART: serial line and oversample tick in,
// received word plus status out.
interface uart_receiver_if #(
    parameter int DBITS = 8
);
    logic             rx;
    logic             s_tick;
    logic [DBITS-1:0] dout;
    logic             rx_done;
    logic             frame_err;
    logic             busy;

    // The side that owns the serial line and the baud tick.
    modport master (
        output rx,
        output s_tick,
        input  dout,
        input  rx_done,
        input  frame_err,
        input  busy
    );

    // The receiver itself.
    modport slave (
        input  rx,
        input  s_tick,
        output dout,
        output rx_done,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled, DBITS data bits LSB first, SB_TICK ticks of
// stop bit. Delivers each byte as a one-clk rx_done pulse with a held data
// word and a framing-error flag.
module uart_receiver #(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16
) (
    input logic            clk,
    input logic            rst_n,
    uart_receiver_if.slave bus
);
    localparam int SW = (SB_TICK > 16) ? 5 : 4;

    localparam logic [SW-1:0] S_MID       = SW'(7);
    localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST      = 3'(DBITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [2:0]       n_q, n_d;
    logic [DBITS-1:0] b_q, b_d;
    logic [DBITS-1:0] dout_q, dout_d;
    logic             done_q, done_d;
    logic             fe_q, fe_d;
    logic             rx_meta, rx_s;

    // Two-flop synchroniser for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // value of its neighbour; blocking here would collapse the two stages.
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            fe_q    <= fe_d;
        end
    end

    // Next-state logic: start detection is immediate, everything else moves on s_tick.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        fe_d    = fe_q;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            // Line went high again before mid start bit: noise.
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        // Shift in from the top so the first bit lands in the LSB.
                        b_d = (b_q >> 1) | (DBITS'(rx_s) << (DBITS - 1));
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        dout_d  = b_q;
                        fe_d    = ~rx_s;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dout      = dout_q;
    assign bus.rx_done   = done_q;
    assign bus.frame_err = fe_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: an 8N1 instance driven by a 27-clk tick
// and a 7-bit, two-stop-bit instance with the tick tied high.
module tb_uart_receiver;
    localparam int BIT_CLK      = 432;  // 16 ticks x 27 clk
    localparam int BAD_STOP_CLK = 240;  // low stop bit held just past its sample point
    localparam int NV           = 5;

    logic clk;
    logic rst_n;
    logic abort_tx;

    int errors;
    int checks;

    uart_receiver_if #(.DBITS(8)) ifc1 ();
    uart_receiver_if #(.DBITS(7)) ifc2 ();

    uart_receiver #(.DBITS(8), .SB_TICK(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc1.slave)
    );

    uart_receiver #(.DBITS(7), .SB_TICK(32)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 16x tick for instance 1: one clk in every 27.
    initial begin
        int cnt;
        cnt         = 0;
        ifc1.s_tick = 1'b0;
        forever begin
            @(negedge clk);
            cnt         = (cnt == 26) ? 0 : cnt + 1;
            ifc1.s_tick = (cnt == 26);
        end
    end

    // Record every rx_done pulse of instance 1 with the context around it.
    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       busy;
        logic       prev_busy;
        int         cyc;
    } done_t;

    done_t done_q[$];
    int    cyc;
    logic  prev_busy1;

    initial begin
        cyc        = 0;
        prev_busy1 = 1'b0;
    end

    always @(negedge clk) begin : mon1
        done_t e;
        cyc = cyc + 1;
        if (ifc1.rx_done === 1'b1) begin
            e.data      = ifc1.dout;
            e.fe        = ifc1.frame_err;
            e.busy      = ifc1.busy;
            e.prev_busy = prev_busy1;
            e.cyc       = cyc;
            done_q.push_back(e);
        end
        prev_busy1 = ifc1.busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One 8N1 frame on instance 1; a low stop bit returns high after BAD_STOP_CLK.
    task automatic send_frame(input logic [7:0] data, input logic stop_lvl);
        logic [9:0] bits;
        bits = {stop_lvl, data, 1'b0};
        for (int k = 0; k < 10 * BIT_CLK; k++) begin
            if (abort_tx) begin
                ifc1.rx = 1'b1;
                return;
            end
            if ((k / BIT_CLK) == 9 && (k % BIT_CLK) >= BAD_STOP_CLK)
                ifc1.rx = 1'b1;
            else
                ifc1.rx = bits[k / BIT_CLK];
            @(negedge clk);
        end
        ifc1.rx = 1'b1;
    endtask

    task automatic wait_done(input string name, input int n, input int budget);
        int waited;
        waited = 0;
        while (done_q.size() < n && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check(name, done_q.size(), n);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_lvl;
        logic       gap;
        logic [7:0] exp_dout;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        int n0;
        int lat;
        int done2;
        logic [9:0]  f2;
        logic [6:0]  d2;
        logic [6:0]  exp7;

        errors   = 0;
        checks   = 0;
        abort_tx = 1'b0;
        ifc1.rx  = 1'b1;
        ifc2.rx  = 1'b1;
        ifc2.s_tick = 1'b1;
        rst_n    = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_dout",      ifc1.dout,      0);
        check("reset_rx_done",   ifc1.rx_done,   0);
        check("reset_frame_err", ifc1.frame_err, 0);
        check("reset_busy",      ifc1.busy,      0);
        check("reset_dout2",     ifc2.dout,      0);
        check("reset_busy2",     ifc2.busy,      0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // data, stop level, idle gap before, expected dout, expected frame_err
        vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0};  // back-to-back with 0xA3
        vecs[3] = '{8'hF0, 1'b0, 1'b1, 8'hF0, 1'b1};  // stop bit low
        vecs[4] = '{8'h0F, 1'b1, 1'b1, 8'h0F, 1'b0};

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].gap) repeat (BIT_CLK) @(negedge clk);
            send_frame(vecs[i].data, vecs[i].stop_lvl);
        end
        wait_done("frame_count", NV, 1000);

        for (int i = 0; i < NV; i++) begin
            if (i < done_q.size()) begin
                check($sformatf("dout_%0d", i),      done_q[i].data,      vecs[i].exp_dout);
                check($sformatf("frame_err_%0d", i), done_q[i].fe,        vecs[i].exp_fe);
                check($sformatf("busy_at_done_%0d", i), done_q[i].busy,   0);
                check($sformatf("busy_before_done_%0d", i), done_q[i].prev_busy, 1);
            end
        end
        // Start edges 4320 clk apart with the tick phase repeating every 160 ticks.
        if (done_q.size() >= 3)
            check("b2b_spacing", done_q[2].cyc - done_q[1].cyc, 4320);

        // Glitch: 81 clk low is rejected at the mid-start check.
        n0 = done_q.size();
        ifc1.rx = 1'b0;
        repeat (40) @(negedge clk);
        check("glitch_busy_high", ifc1.busy, 1);
        repeat (41) @(negedge clk);
        ifc1.rx = 1'b1;
        repeat (600) @(negedge clk);
        check("glitch_busy_low", ifc1.busy, 0);
        check("glitch_no_done", done_q.size(), n0);
        check("glitch_dout",    ifc1.dout, 8'h0F);

        // Reset during data bit 4 of 0x3C; transmitter abandons the frame too.
        repeat (BIT_CLK) @(negedge clk);
        n0 = done_q.size();
        fork
            send_frame(8'h3C, 1'b1);
            begin
                repeat (5 * BIT_CLK + 200) @(negedge clk);
                rst_n    = 1'b0;
                abort_tx = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        abort_tx = 1'b0;
        @(negedge clk);
        check("midreset_dout",      ifc1.dout,      0);
        check("midreset_frame_err", ifc1.frame_err, 0);
        check("midreset_busy",      ifc1.busy,      0);
        repeat (BIT_CLK) @(negedge clk);
        check("midreset_no_done", done_q.size(), n0);
        send_frame(8'h81, 1'b1);
        wait_done("after_reset_count", n0 + 1, 1000);
        if (done_q.size() > n0) begin
            check("after_reset_dout", done_q[n0].data, 8'h81);
            check("after_reset_fe",   done_q[n0].fe,   0);
        end
        check("after_reset_dout_held", ifc1.dout, 8'h81);

        // Tick tied high, 7 data bits, 2 stop bits, 16 clk/bit.
        // Fall seen at clk 3 (2 sync + 1), DATA at 11, bit k sampled at 27+16k,
        // STOP entered at 123, last stop tick at 155 -> pulse seen 155 clk after fall.
        d2    = 7'h5A;
        exp7  = 7'h5A;
        f2    = {2'b11, d2, 1'b0};
        lat   = -1;
        done2 = 0;
        for (int k = 0; k < 200; k++) begin
            ifc2.rx = (k < 160) ? f2[k / 16] : 1'b1;
            @(negedge clk);
            if (ifc2.rx_done === 1'b1) begin
                done2++;
                if (lat < 0) lat = k + 1;
                check("tick_high_dout", ifc2.dout,      exp7);
                check("tick_high_fe",   ifc2.frame_err, 0);
            end
        end
        check("tick_high_done_count", done2, 1);
        check("tick_high_latency",    lat,   155);
        check("tick_high_busy_end",   ifc2.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end
endmodule
